// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - CPU request/response handshake bundle for ram_ctrl
interface ram_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 8
) ();
    // Request channel (CPU -> controller)
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    // Response channel (controller -> CPU), reads only
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    // CPU side
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        output rsp_ready
    );

    // Controller side
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        input  rsp_ready
    );
endinterface

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - single-outstanding CPU front end for a synchronous RAM with optional fill after reset
module ram_ctrl #(
    parameter int            AW       = 4,
    parameter int            DW       = 8,
    parameter bit            INIT_EN  = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_ctrl_if.slave     bus,
    output logic          init_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wr,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_CAP  = 3'd4;
    localparam logic [2:0] ST_RSP  = 3'd5;

    localparam logic [2:0]    RESET_STATE = INIT_EN ? ST_INIT : ST_IDLE;
    localparam logic [AW-1:0] LAST_ADDR   = '1;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          accept;
    logic          init_last;

    // A request is taken only while idle; anything offered elsewhere is ignored
    assign accept    = (state == ST_IDLE) && bus.req_valid;
    assign init_last = (state == ST_INIT) && (init_cnt == LAST_ADDR);

    // Next-state decode: fill sweep, then one request at a time
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_last) state_nxt = ST_IDLE;
            ST_IDLE: if (bus.req_valid) state_nxt = bus.req_we ? ST_WR : ST_RD;
            ST_WR:   state_nxt = ST_IDLE;
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = ST_RSP;
            ST_RSP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_nxt;
    end

    // Fill address counter; restarts from 0 on every reset
    always_ff @(posedge clk) begin
        if (!rst_n)                 init_cnt <= '0;
        else if (state == ST_INIT)  init_cnt <= init_cnt + 1'b1;
    end

    // Fill-complete flag, sticky until the next reset
    always_ff @(posedge clk) begin
        if (!rst_n)          init_done <= !INIT_EN;
        else if (init_last)  init_done <= 1'b1;
    end

    // Request latch so the RAM sees stable address/data after the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Response register: load from RAM output in CAP, hold until the CPU takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (state == ST_CAP) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ram_rdata;
        end else if ((state == ST_RSP) && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // RAM pin drive; strobes are gated by rst_n so nothing reaches the RAM during reset
    always_comb begin
        ram_wr    = rst_n && ((state == ST_INIT) || (state == ST_WR));
        ram_rd    = rst_n && (state == ST_RD);
        ram_addr  = (state == ST_INIT) ? init_cnt : addr_q;
        ram_wdata = (state == ST_INIT) ? INIT_VAL : wdata_q;
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - directed and random checks of ram_ctrl against a memory-array reference
module tb_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_wr;
    logic       ram_rd;
    logic [7:0] ram_rdata;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned overlap = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] mem [16];
    bit         ram_loaded;

    ram_ctrl_if #(.AW(4), .DW(8)) bus ();

    ram_ctrl #(.AW(4), .DW(8), .INIT_EN(1'b1), .INIT_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wr    (ram_wr),
        .ram_rd    (ram_rd),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // 16x8 synchronous RAM; preloaded with nonzero junk so the fill is observable
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h80 | 8'(i);
            ram_loaded <= 1'b1;
            ram_rdata  <= 8'h00;
        end else begin
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            if (ram_rd) ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_wr && ram_rd) overlap <= overlap + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has just released reset and let it settle
    task automatic check_init(input bit pulse);
        for (int i = 0; i < 16; i++) begin
            check("init_wr", ram_wr, 1);
            check("init_rd", ram_rd, 0);
            check("init_addr", ram_addr, i);
            check("init_data", ram_wdata, 8'h00);
            check("init_ready", bus.req_ready, 0);
            check("init_done_lo", init_done, 0);
            check("init_rsp", bus.rsp_valid, 0);
            bus.req_valid = pulse && (i == 5);
            bus.req_we    = 1'b1;
            bus.req_addr  = 4'd4;
            bus.req_wdata = 8'h77;
            tick();
        end
        bus.req_valid = 1'b0;
        check("init_done_hi", init_done, 1);
        check("post_init_ready", bus.req_ready, 1);
        check("post_init_wr", ram_wr, 0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        check("wr_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'($urandom);
        bus.req_wdata = 8'($urandom);
        check("wr_strobe", ram_wr, 1);
        check("wr_addr", ram_addr, a);
        check("wr_data", ram_wdata, d);
        check("wr_busy", bus.req_ready, 0);
        tick();
        ref_mem[a] = d;
        check("wr_done_ready", bus.req_ready, 1);
        check("wr_no_rsp", bus.rsp_valid, 0);
    endtask

    task automatic do_read(input logic [3:0] a, input int stall);
        logic [7:0] exp;
        exp = ref_mem[a];
        check("rd_ready", bus.req_ready, 1);
        bus.rsp_ready = (stall == 0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'($urandom);
        check("rd_strobe", ram_rd, 1);
        check("rd_no_wr", ram_wr, 0);
        check("rd_addr", ram_addr, a);
        check("rd_rsp_early1", bus.rsp_valid, 0);
        tick();
        check("rd_rsp_early2", bus.rsp_valid, 0);
        check("rd_cap_strobe", ram_rd, 0);
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_data", bus.rsp_rdata, exp);
        for (int k = 0; k < stall; k++) begin
            tick();
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_data", bus.rsp_rdata, exp);
            check("stall_busy", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("rsp_done_valid", bus.rsp_valid, 0);
        check("rsp_done_ready", bus.req_ready, 1);
        check("rsp_keep_data", bus.rsp_rdata, exp);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 8'd0;
        bus.rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_wr", ram_wr, 0);
        check("rst_rd", ram_rd, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_rdata, 8'h00);
        check("rst_init_done", init_done, 0);
        check("rst_ready", bus.req_ready, 0);

        // Fill sweep with a request offered mid-way that must be ignored
        rst_n = 1'b1;
        #1;
        check_init(1'b1);
        for (int a = 0; a < 16; a++) do_read(4'(a), 0);

        // Basic write then read-back
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 0);

        // Response held through back-pressure
        do_write(4'd7, 8'h3C);
        do_read(4'd7, 5);

        // Back-to-back writes with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd15;
        bus.req_wdata = 8'hFF;
        tick();
        check("b2b_wr1", ram_wr, 1);
        check("b2b_addr1", ram_addr, 15);
        check("b2b_busy", bus.req_ready, 0);
        bus.req_addr  = 4'd0;
        tick();
        check("b2b_ready", bus.req_ready, 1);
        check("b2b_gap", ram_wr, 0);
        tick();
        bus.req_valid = 1'b0;
        check("b2b_wr2", ram_wr, 1);
        check("b2b_addr2", ram_addr, 0);
        check("b2b_data2", ram_wdata, 8'hFF);
        tick();
        ref_mem[15] = 8'hFF;
        ref_mem[0]  = 8'hFF;
        do_read(4'd15, 0);
        do_read(4'd0, 0);

        // Random traffic against the reference array
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) do_write(4'($urandom), 8'($urandom));
            else                           do_read(4'($urandom), int'($urandom_range(0, 3)));
        end
        check("no_overlap", overlap, 0);

        // Reset while a read is in the RD state
        do_write(4'd9, 8'h5A);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd9;
        tick();
        bus.req_valid = 1'b0;
        check("mid_rd_strobe", ram_rd, 1);
        rst_n = 1'b0;
        #1;
        check("rst_gates_rd", ram_rd, 0);
        check("rst_gates_wr", ram_wr, 0);
        tick();
        check("rst_drop_rsp", bus.rsp_valid, 0);
        tick();
        check("rst_drop_rsp2", bus.rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        check_init(1'b0);
        do_read(4'd9, 0);
        do_read(4'd4, 1);
        do_read(4'd15, 0);
        check("final_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
